// File: rtl/gray_matrix_3x3_gen.sv
// gray_matrix_3x3_gen: builds a 3x3 pixel window from a raster grey stream using two line buffers.
// Define MATRIX_BORDER_ZERO_EN to force taps whose source lies outside the image to zero.
module gray_matrix_3x3_gen #(
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480,
    parameter int DW        = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          per_frame_vsync,
    input  logic          per_frame_href,
    input  logic          per_frame_clken,
    input  logic [DW-1:0] per_img_gray,
    output logic          matrix_frame_vsync,
    output logic          matrix_frame_href,
    output logic          matrix_frame_clken,
    output logic [DW-1:0] matrix_p11,
    output logic [DW-1:0] matrix_p12,
    output logic [DW-1:0] matrix_p13,
    output logic [DW-1:0] matrix_p21,
    output logic [DW-1:0] matrix_p22,
    output logic [DW-1:0] matrix_p23,
    output logic [DW-1:0] matrix_p31,
    output logic [DW-1:0] matrix_p32,
    output logic [DW-1:0] matrix_p33
);
    localparam int AW = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
    localparam int XW = $clog2(IMG_HDISP + 1);
    localparam int YW = (IMG_VDISP > 1) ? $clog2(IMG_VDISP) : 1;
    localparam logic [XW-1:0] X_END  = XW'(IMG_HDISP);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_VDISP - 1);

    logic          vsync_p1, href_p1, vld_p1;
    logic          vsync_p2, href_p2, vld_p2;
    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;
    logic          vsync_rise_p0, href_fall_p0, accept_p0;
    logic [AW-1:0] addr_p0;

    logic [DW-1:0] lb1 [IMG_HDISP];
    logic [DW-1:0] lb2 [IMG_HDISP];

    logic [DW-1:0] col_top_p1, col_mid_p1, col_bot_p1;
    logic [DW-1:0] w11_p2, w12_p2, w13_p2;
    logic [DW-1:0] w21_p2, w22_p2, w23_p2;
    logic [DW-1:0] w31_p2, w32_p2, w33_p2;
    logic          top_kill, mid_kill, c1_kill, c2_kill;

    // Stage 0: input decode and x/y position of the incoming pixel
    assign vsync_rise_p0 = per_frame_vsync && !vsync_p1;
    assign href_fall_p0  = href_p1 && !per_frame_href;
    assign accept_p0     = per_frame_clken && per_frame_href && (x_cnt < X_END);
    assign addr_p0       = x_cnt[AW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_p1 <= 1'b0;
            href_p1  <= 1'b0;
            x_cnt    <= '0;
            y_cnt    <= '0;
        end else begin
            vsync_p1 <= per_frame_vsync;
            href_p1  <= per_frame_href;
            if (vsync_rise_p0) begin
                x_cnt <= '0;
                y_cnt <= '0;
            end else if (href_fall_p0) begin
                x_cnt <= '0;
                if (y_cnt != Y_LAST)
                    y_cnt <= y_cnt + YW'(1);
            end else if (accept_p0) begin
                x_cnt <= x_cnt + XW'(1);
            end
        end
    end

    // Line buffers are plain RAM: no reset, read-before-write so each column shifts up a row
    always_ff @(posedge clk) begin
        if (accept_p0) begin
            lb1[addr_p0] <= per_img_gray;
            lb2[addr_p0] <= lb1[addr_p0];
        end
    end

    // Stage 1: one vertical column (rows y-2, y-1, y) per accepted pixel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            col_top_p1 <= '0;
            col_mid_p1 <= '0;
            col_bot_p1 <= '0;
        end else begin
            vld_p1 <= accept_p0;
            if (accept_p0) begin
                col_top_p1 <= lb2[addr_p0];
                col_mid_p1 <= lb1[addr_p0];
                col_bot_p1 <= per_img_gray;
            end
        end
    end

`ifdef MATRIX_BORDER_ZERO_EN
    logic [AW-1:0] x_p1;
    logic [YW-1:0] y_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_p1 <= '0;
            y_p1 <= '0;
        end else if (accept_p0) begin
            x_p1 <= addr_p0;
            y_p1 <= y_cnt;
        end
    end

    // Masking at shift time is enough: in-image values are never zeroed, so they shift on intact
    assign top_kill = (y_p1 <= YW'(1));
    assign mid_kill = (y_p1 == '0);
    assign c1_kill  = (x_p1 <= AW'(1));
    assign c2_kill  = (x_p1 == '0);
`else
    assign top_kill = 1'b0;
    assign mid_kill = 1'b0;
    assign c1_kill  = 1'b0;
    assign c2_kill  = 1'b0;
`endif

    // Stage 2: horizontal shift of the 3x3 window, held between strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_p2 <= 1'b0;
            href_p2  <= 1'b0;
            vld_p2   <= 1'b0;
            w11_p2 <= '0; w12_p2 <= '0; w13_p2 <= '0;
            w21_p2 <= '0; w22_p2 <= '0; w23_p2 <= '0;
            w31_p2 <= '0; w32_p2 <= '0; w33_p2 <= '0;
        end else begin
            vsync_p2 <= vsync_p1;
            href_p2  <= href_p1;
            vld_p2   <= vld_p1;
            if (vld_p1) begin
                w13_p2 <= top_kill              ? '0 : col_top_p1;
                w12_p2 <= (top_kill || c2_kill) ? '0 : w13_p2;
                w11_p2 <= (top_kill || c1_kill) ? '0 : w12_p2;
                w23_p2 <= mid_kill              ? '0 : col_mid_p1;
                w22_p2 <= (mid_kill || c2_kill) ? '0 : w23_p2;
                w21_p2 <= (mid_kill || c1_kill) ? '0 : w22_p2;
                w33_p2 <= col_bot_p1;
                w32_p2 <= c2_kill ? '0 : w33_p2;
                w31_p2 <= c1_kill ? '0 : w32_p2;
            end
        end
    end

    assign matrix_frame_vsync = vsync_p2;
    assign matrix_frame_href  = href_p2;
    assign matrix_frame_clken = vld_p2;
    assign matrix_p11 = w11_p2;
    assign matrix_p12 = w12_p2;
    assign matrix_p13 = w13_p2;
    assign matrix_p21 = w21_p2;
    assign matrix_p22 = w22_p2;
    assign matrix_p23 = w23_p2;
    assign matrix_p31 = w31_p2;
    assign matrix_p32 = w32_p2;
    assign matrix_p33 = w33_p2;

endmodule

// File: tb/tb_gray_matrix_3x3_gen.sv
// Directed testbench for gray_matrix_3x3_gen on an 8x6 image; honours MATRIX_BORDER_ZERO_EN.
`timescale 1ns/1ps
module tb_gray_matrix_3x3_gen;
    localparam int HD = 8;
    localparam int VD = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vs = 1'b0, hs = 1'b0, ce = 1'b0;
    logic [7:0] px = 8'h00;
    logic       m_vs, m_hs, m_ce;
    logic [7:0] m11, m12, m13, m21, m22, m23, m31, m32, m33;

    int n_cmp  = 0;
    int n_fail = 0;

    gray_matrix_3x3_gen #(.IMG_HDISP(HD), .IMG_VDISP(VD), .DW(8)) dut (
        .clk(clk), .rst(rst),
        .per_frame_vsync(vs), .per_frame_href(hs), .per_frame_clken(ce), .per_img_gray(px),
        .matrix_frame_vsync(m_vs), .matrix_frame_href(m_hs), .matrix_frame_clken(m_ce),
        .matrix_p11(m11), .matrix_p12(m12), .matrix_p13(m13),
        .matrix_p21(m21), .matrix_p22(m22), .matrix_p23(m23),
        .matrix_p31(m31), .matrix_p32(m32), .matrix_p33(m33)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish want finish");
        $fatal(1);
    end

    function automatic logic [71:0] win();
        return {m11, m12, m13, m21, m22, m23, m31, m32, m33};
    endfunction

    task automatic tick(input logic v, input logic h, input logic c, input logic [7:0] p);
        vs = v; hs = h; ce = c; px = p;
        @(posedge clk);
        #1;
    endtask

    task automatic frame_start();
        tick(1'b0, 1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 1'b0, 8'h00);
        tick(1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic frame_end();
        tick(1'b1, 1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    // Drives one line plus a 3-cycle href-low gap and records what the outputs did
    task automatic drive_line(input int y, input int ncol, input bit gapped, input bit use_const,
                              input logic [7:0] cval, input int tx,
                              output int strobes, output logic [71:0] cap,
                              output int lat_err, output int stab_err);
        int prev_acc;
        int nt;
        logic [71:0] last;
        strobes = 0; lat_err = 0; stab_err = 0; prev_acc = -1;
        cap = 'x;
        last = win();
        nt = gapped ? 2 * ncol : ncol;
        for (int t = 0; t < nt + 3; t++) begin
            int k;
            int acc;
            bit drive_px;
            logic [7:0] p;
            k = gapped ? t / 2 : t;
            drive_px = (t < nt) && (!gapped || (t % 2 == 0));
            p = use_const ? cval : 8'(16 * y + k);
            if (t < nt) tick(1'b1, 1'b1, drive_px, drive_px ? p : 8'h00);
            else        tick(1'b1, 1'b0, 1'b0, 8'h00);
            acc = (drive_px && k < HD) ? k : -1;
            if (m_ce !== (prev_acc >= 0)) lat_err++;
            if (m_ce === 1'b1) begin
                strobes++;
                if (prev_acc == tx) cap = win();
            end else if (win() !== last) begin
                stab_err++;
            end
            last = win();
            prev_acc = acc;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; vs = 1'b0; hs = 1'b0; ce = 1'b0; px = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({win(), m_vs, m_hs, m_ce} !== 75'd0) begin
            n_fail++; $display("FAIL reset_state: got %h want 0", {win(), m_vs, m_hs, m_ce});
        end
        rst = 1'b0;
        frame_start();
        for (int x = 0; x < 4; x++) tick(1'b1, 1'b1, 1'b1, 8'(100 + x));
        n_cmp++;
        if ({m31, m32, m33} !== 24'h646566) begin
            n_fail++; $display("FAIL prereset_bottom_row: got %h want 646566", {m31, m32, m33});
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({win(), m_vs, m_hs, m_ce} !== 75'd0) begin
            n_fail++; $display("FAIL async_reset_clear: got %h want 0", {win(), m_vs, m_hs, m_ce});
        end
        @(posedge clk);
        #1 rst = 1'b0;
        tick(1'b1, 1'b1, 1'b1, 8'h5A);
        n_cmp++;
        if (m_ce !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_t1_clken: got %b want 0", m_ce);
        end
        tick(1'b1, 1'b1, 1'b0, 8'h00);
        n_cmp++;
        if ({m_ce, m33} !== {1'b1, 8'h5A}) begin
            n_fail++; $display("FAIL post_reset_t2: got clken=%b p33=%h want clken=1 p33=5a", m_ce, m33);
        end
        tick(1'b1, 1'b0, 1'b0, 8'h00);
        frame_end();
    endtask

    task automatic test_ramp(input bit gapped);
        int s, le, se;
        logic [71:0] c;
        logic [71:0] c43;
        c43 = 'x;
        frame_start();
        for (int y = 0; y < VD; y++) begin
            drive_line(y, HD, gapped, 1'b0, 8'h00, (y == 3) ? 4 : -1, s, c, le, se);
            if (y == 3) c43 = c;
            n_cmp++;
            if (s !== HD) begin
                n_fail++; $display("FAIL ramp_strobes g=%0d y=%0d: got %0d want %0d", gapped, y, s, HD);
            end
            n_cmp++;
            if (le !== 0) begin
                n_fail++; $display("FAIL ramp_latency g=%0d y=%0d: got %0d errors want 0", gapped, y, le);
            end
            n_cmp++;
            if (se !== 0) begin
                n_fail++; $display("FAIL ramp_hold g=%0d y=%0d: got %0d changes want 0", gapped, y, se);
            end
        end
        frame_end();
        n_cmp++;
        if (c43 !== 72'h12_13_14_22_23_24_32_33_34) begin
            n_fail++; $display("FAIL ramp_window_4_3 g=%0d: got %h want 121314222324323334", gapped, c43);
        end
    endtask

    task automatic test_overlength();
        int s, le, se;
        logic [71:0] c;
        logic [71:0] exp_w;
`ifdef MATRIX_BORDER_ZERO_EN
        exp_w = 72'h00_00_00_00_01_02_10_11_12;
`else
        exp_w = 72'h50_51_52_00_01_02_10_11_12;
`endif
        frame_start();
        drive_line(0, 10, 1'b0, 1'b0, 8'h00, -1, s, c, le, se);
        n_cmp++;
        if (s !== HD) begin
            n_fail++; $display("FAIL overlength_strobes: got %0d want %0d", s, HD);
        end
        n_cmp++;
        if (le !== 0) begin
            n_fail++; $display("FAIL overlength_latency: got %0d errors want 0", le);
        end
        drive_line(1, HD, 1'b0, 1'b0, 8'h00, 2, s, c, le, se);
        n_cmp++;
        if (c !== exp_w) begin
            n_fail++; $display("FAIL overlength_window_2_1: got %h want %h", c, exp_w);
        end
        frame_end();
    endtask

    task automatic test_border();
        int s, le, se;
        logic [71:0] c;
`ifdef MATRIX_BORDER_ZERO_EN
        frame_start();
        drive_line(0, HD, 1'b0, 1'b0, 8'h00, 1, s, c, le, se);
        frame_end();
        n_cmp++;
        if (c !== 72'd1) begin
            n_fail++; $display("FAIL border_zero_1_0: got %h want 000000000000000001", c);
        end
`else
        frame_start();
        for (int y = 0; y < VD; y++) drive_line(y, HD, 1'b0, 1'b1, 8'd50, -1, s, c, le, se);
        frame_end();
        frame_start();
        drive_line(0, HD, 1'b0, 1'b1, 8'd200, 3, s, c, le, se);
        frame_end();
        n_cmp++;
        if (c !== 72'h32_32_32_32_32_32_C8_C8_C8) begin
            n_fail++; $display("FAIL border_stale_3_0: got %h want 323232323232c8c8c8", c);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_ramp(1'b0);
        test_ramp(1'b1);
        test_overlength();
        test_border();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
